// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
package div_pkg;

  // Divider control states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Bits needed for a counter that runs WIDTH-1 down to 0
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor magnitude, keep the difference if it fits.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // Trial subtraction in WIDTH+1 bits. Because rem_in < dvs always holds
  // (the partial remainder starts at zero), trial < 2*dvs. The difference
  // therefore never reaches 2^WIDTH when it is non-negative, so bit WIDTH
  // of diff is exactly the borrow (trial < dvs).
  always_comb begin
    trial   = {rem_in, bit_in};
    diff    = trial - {1'b0, dvs};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, with signed or
// unsigned operation selected per request and valid/ready on both sides.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero,
  output logic             overflow
);

  localparam int               CNT_W   = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic             sign_reg;
  logic [WIDTH-1:0] dvd_reg;     // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] dvs_reg;     // divisor magnitude
  logic [WIDTH-1:0] part_reg;    // partial remainder
  logic [WIDTH-1:0] q_reg;       // quotient magnitude being built
  logic             neg_q_reg, neg_r_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] quot_reg, rem_reg;
  logic             div_zero_reg, overflow_reg;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (part_reg),
    .bit_in (dvd_reg[WIDTH-1]),
    .dvs    (dvs_reg),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; a zero divisor bypasses the iteration entirely
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = (b == '0) ? DONE : PREP;
      PREP: state_next = RUN;
      RUN:  if (cnt_reg == '0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg        <= '0;
      b_reg        <= '0;
      sign_reg     <= 1'b0;
      dvd_reg      <= '0;
      dvs_reg      <= '0;
      part_reg     <= '0;
      q_reg        <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      cnt_reg      <= '0;
      quot_reg     <= '0;
      rem_reg      <= '0;
      div_zero_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            sign_reg     <= sign;
            div_zero_reg <= (b == '0);
            overflow_reg <= 1'b0;
            if (b == '0) begin
              quot_reg <= '1;
              rem_reg  <= a;
            end
          end
        end
        PREP: begin
          // Magnitudes are unsigned, so |MIN_NEG| fits in WIDTH bits
          dvd_reg      <= (sign_reg && a_reg[WIDTH-1]) ? -a_reg : a_reg;
          dvs_reg      <= (sign_reg && b_reg[WIDTH-1]) ? -b_reg : b_reg;
          part_reg     <= '0;
          q_reg        <= '0;
          cnt_reg      <= CNT_W'(WIDTH - 1);
          neg_q_reg    <= sign_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
          neg_r_reg    <= sign_reg & a_reg[WIDTH-1];
          overflow_reg <= sign_reg && (a_reg == MIN_NEG) && (b_reg == '1);
        end
        RUN: begin
          part_reg <= step_rem;
          q_reg    <= {q_reg[WIDTH-2:0], step_q};
          dvd_reg  <= {dvd_reg[WIDTH-2:0], 1'b0};
          cnt_reg  <= cnt_reg - CNT_W'(1);
        end
        FIX: begin
          // Overflow case wraps naturally: -(-2^(W-1)) == -2^(W-1) mod 2^W
          quot_reg <= neg_q_reg ? -q_reg : q_reg;
          rem_reg  <= neg_r_reg ? -part_reg : part_reg;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign quot      = quot_reg;
  assign rem       = rem_reg;
  assign div_zero  = div_zero_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider at WIDTH=8.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, sign, out_valid, out_ready;
  logic         div_zero, overflow;
  logic [W-1:0] a, b, quot, rem;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] r_q, r_r;
  logic         r_dz, r_ov;
  int           r_lat;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sign     (sign),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands once the divider is idle; returns just after the accept edge
  task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
    int guard = 0;
    while (!in_ready && guard < 40) begin
      tick();
      guard++;
    end
    check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    a = va; b = vb; sign = vs; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for out_valid, counting edges after the accept edge
  task automatic wait_result();
    r_lat = 0;
    while (!out_valid && r_lat < 40) begin
      tick();
      r_lat++;
    end
    check("out_valid_wait", {31'b0, out_valid}, 32'd1);
    r_q = quot; r_r = rem; r_dz = div_zero; r_ov = overflow;
  endtask

  task automatic run_dir(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vs, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input logic eov, input int elat);
    start_op(va, vb, vs);
    wait_result();
    $display("%s: a=%02h b=%02h s=%0d -> q=%02h r=%02h dz=%0d ov=%0d lat=%0d",
             tag, va, vb, vs, r_q, r_r, r_dz, r_ov, r_lat);
    check({tag, ".q"},   {24'b0, r_q}, {24'b0, eq});
    check({tag, ".r"},   {24'b0, r_r}, {24'b0, er});
    check({tag, ".dz"},  {31'b0, r_dz}, {31'b0, edz});
    check({tag, ".ov"},  {31'b0, r_ov}, {31'b0, eov});
    check({tag, ".lat"}, r_lat, elat);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sign = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst.in_ready",  {31'b0, in_ready},  32'd1);
    check("rst.out_valid", {31'b0, out_valid}, 32'd0);
    check("rst.quot",      {24'b0, quot},      32'd0);
    check("rst.rem",       {24'b0, rem},       32'd0);
    check("rst.div_zero",  {31'b0, div_zero},  32'd0);
    check("rst.overflow",  {31'b0, overflow},  32'd0);
    reset = 1'b0;
    tick();

    // Signed vectors
    run_dir("s_42_7",    8'd42,  8'd7,   1'b1, 8'd6,   8'd0,  1'b0, 1'b0, 10);
    run_dir("s_m42_7",   8'hD6,  8'd7,   1'b1, 8'hFA,  8'd0,  1'b0, 1'b0, 10);
    run_dir("s_7_m42",   8'd7,   8'hD6,  1'b1, 8'd0,   8'd7,  1'b0, 1'b0, 10);
    run_dir("s_127_37",  8'd127, 8'd37,  1'b1, 8'd3,   8'd16, 1'b0, 1'b0, 10);
    run_dir("s_m7_2",    8'hF9,  8'd2,   1'b1, 8'hFD,  8'hFF, 1'b0, 1'b0, 10);
    // Unsigned vectors
    run_dir("u_200_3",   8'd200, 8'd3,   1'b0, 8'd66,  8'd2,  1'b0, 1'b0, 10);
    run_dir("u_255_255", 8'd255, 8'd255, 1'b0, 8'd1,   8'd0,  1'b0, 1'b0, 10);
    run_dir("u_0_5",     8'd0,   8'd5,   1'b0, 8'd0,   8'd0,  1'b0, 1'b0, 10);
    run_dir("u_128_255", 8'h80,  8'hFF,  1'b0, 8'd0,   8'h80, 1'b0, 1'b0, 10);
    // Divide by zero, then a normal op clears the flag
    run_dir("dz_42",     8'd42,  8'd0,   1'b0, 8'hFF,  8'd42, 1'b1, 1'b0, 0);
    run_dir("dz_clear",  8'd42,  8'd7,   1'b0, 8'd6,   8'd0,  1'b0, 1'b0, 10);
    // Signed minimum by -1 and by 1
    run_dir("ov_m128_m1", 8'h80, 8'hFF,  1'b1, 8'h80,  8'd0,  1'b0, 1'b1, 10);
    run_dir("s_m128_1",   8'h80, 8'd1,   1'b1, 8'h80,  8'd0,  1'b0, 1'b0, 10);

    // Backpressure: hold DONE for 5 cycles while in_valid is asserted
    out_ready = 1'b0;
    start_op(8'd100, 8'd7, 1'b0);
    wait_result();
    $display("bp: a=64 b=07 s=0 -> q=%02h r=%02h held for 5 cycles", r_q, r_r);
    check("bp.q0", {24'b0, r_q}, 32'd14);
    check("bp.r0", {24'b0, r_r}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      a = 8'd3; b = 8'd1; sign = 1'b0; in_valid = 1'b1;
      tick();
      check("bp.quot",      {24'b0, quot},      32'd14);
      check("bp.rem",       {24'b0, rem},       32'd2);
      check("bp.out_valid", {31'b0, out_valid}, 32'd1);
      check("bp.in_ready",  {31'b0, in_ready},  32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp.idle_in_ready",  {31'b0, in_ready},  32'd1);
    check("bp.idle_out_valid", {31'b0, out_valid}, 32'd0);

    // Reset three cycles into RUN
    start_op(8'd42, 8'd7, 1'b0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    $display("mid-run reset: in_ready=%0d out_valid=%0d q=%02h r=%02h", in_ready, out_valid, quot, rem);
    check("mr.in_ready",  {31'b0, in_ready},  32'd1);
    check("mr.out_valid", {31'b0, out_valid}, 32'd0);
    check("mr.quot",      {24'b0, quot},      32'd0);
    check("mr.rem",       {24'b0, rem},       32'd0);
    check("mr.div_zero",  {31'b0, div_zero},  32'd0);
    check("mr.overflow",  {31'b0, overflow},  32'd0);
    reset = 1'b0;
    run_dir("mr_42_7", 8'd42, 8'd7, 1'b1, 8'd6, 8'd0, 1'b0, 1'b0, 10);

    // Random operations against an integer-division model with output stalls
    for (int i = 0; i < 250; i++) begin
      logic [W-1:0] va, vb, eq, er;
      logic         vs, edz, eov;
      int           sa, sb, mq, mr, stalls;
      va = W'($urandom);
      vb = W'($urandom);
      vs = 1'($urandom);
      if (i % 16 == 0) vb = '0;
      if (i % 23 == 0) begin va = 8'h80; vb = 8'hFF; end
      if (vs) begin sa = $signed(va); sb = $signed(vb); end
      else    begin sa = {24'b0, va}; sb = {24'b0, vb}; end
      edz = 1'b0; eov = 1'b0;
      if (vb == '0) begin
        eq = 8'hFF; er = va; edz = 1'b1;
      end else if (vs && va == 8'h80 && vb == 8'hFF) begin
        eq = 8'h80; er = 8'h00; eov = 1'b1;
      end else begin
        mq = sa / sb;
        mr = sa % sb;
        eq = mq[W-1:0];
        er = mr[W-1:0];
      end
      stalls = $urandom_range(0, 3);
      out_ready = (stalls == 0);
      start_op(va, vb, vs);
      wait_result();
      $display("rnd%0d: a=%02h b=%02h s=%0d -> q=%02h r=%02h dz=%0d ov=%0d (model q=%02h r=%02h) stalls=%0d",
               i, va, vb, vs, r_q, r_r, r_dz, r_ov, eq, er, stalls);
      check("rnd.q",  {24'b0, r_q},  {24'b0, eq});
      check("rnd.r",  {24'b0, r_r},  {24'b0, er});
      check("rnd.dz", {31'b0, r_dz}, {31'b0, edz});
      check("rnd.ov", {31'b0, r_ov}, {31'b0, eov});
      for (int s = 0; s < stalls; s++) begin
        tick();
        check("rnd.hold_q", {24'b0, quot}, {24'b0, r_q});
        check("rnd.hold_v", {31'b0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
